// File: rtl/y_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : y_alu_seq
// Purpose  : Execute-stage sequencer acting as the initiator of a
//            combinational 32-bit ALU. Accepts one decoded instruction
//            bundle (valid/ready), decodes opcode/funct into the ALU op,
//            drives registered ALU operands, captures the ALU result and
//            zero flag, and presents a result bundle (valid/ready).
// Ports    : clk_i, rst_ni                 - clock, sync active-low reset
//            in_valid_i/in_ready_o         - input handshake
//            in_inst_i, in_rs_i, in_rt_i   - instruction word and operands
//            alu_a_o, alu_b_o, alu_op_o    - registered ALU controls
//            alu_z_i, alu_zero_i           - ALU result and zero flag
//            out_valid_o/out_ready_i       - output handshake
//            out_result_o, out_zero_o      - captured result / zero flag
//            out_wb_o, out_mem_o,
//            out_taken_o, out_err_o        - mutually exclusive flags
// Revision : 1.0 - initial release
// ============================================================================
module y_alu_seq #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_inst_i,
  input  logic [W-1:0] in_rs_i,
  input  logic [W-1:0] in_rt_i,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic [2:0]   alu_op_o,
  input  logic [W-1:0] alu_z_i,
  input  logic         alu_zero_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_result_o,
  output logic         out_zero_o,
  output logic         out_wb_o,
  output logic         out_mem_o,
  output logic         out_taken_o,
  output logic         out_err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // --------------------------------------------------------------------------
  // Instruction decode (combinational, from the presented bundle)
  // --------------------------------------------------------------------------
  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [W-1:0] imm_sext;
  logic         dec_legal;
  logic [2:0]   dec_op;
  logic         dec_use_imm;
  logic         dec_wb;
  logic         dec_mem;
  logic         dec_br;

  assign opcode   = in_inst_i[31:26];
  assign funct    = in_inst_i[5:0];
  assign imm_sext = {{(W-16){in_inst_i[15]}}, in_inst_i[15:0]};

  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = OP_AND;
    dec_use_imm = 1'b0;
    dec_wb      = 1'b0;
    dec_mem     = 1'b0;
    dec_br      = 1'b0;
    case (opcode)
      6'h00: begin
        dec_legal = 1'b1;
        dec_wb    = 1'b1;
        case (funct)
          6'h20:   dec_op = OP_ADD;
          6'h22:   dec_op = OP_SUB;
          6'h24:   dec_op = OP_AND;
          6'h25:   dec_op = OP_OR;
          6'h2A:   dec_op = OP_SLT;
          default: begin
            dec_legal = 1'b0;
            dec_wb    = 1'b0;
          end
        endcase
      end
      6'h08: begin
        dec_legal   = 1'b1;
        dec_op      = OP_ADD;
        dec_use_imm = 1'b1;
        dec_wb      = 1'b1;
      end
      6'h23, 6'h2B: begin
        dec_legal   = 1'b1;
        dec_op      = OP_ADD;
        dec_use_imm = 1'b1;
        dec_mem     = 1'b1;
      end
      6'h04: begin
        dec_legal = 1'b1;
        dec_op    = OP_SUB;
        dec_br    = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  logic [1:0]   state_q,  state_d;
  logic [W-1:0] alu_a_q,  alu_a_d;
  logic [W-1:0] alu_b_q,  alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [W-1:0] result_q, result_d;
  logic         zero_q,   zero_d;
  logic         wb_q,     wb_d;
  logic         mem_q,    mem_d;
  logic         br_q,     br_d;
  logic         taken_q,  taken_d;
  logic         err_q,    err_d;
  logic         accept;

  assign in_ready_o = rst_ni & (state_q == S_IDLE);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    zero_d   = zero_q;
    wb_d     = wb_q;
    mem_d    = mem_q;
    br_d     = br_q;
    taken_d  = taken_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // A fresh bundle clears the previous result so stale values never
          // accompany a new instruction.
          result_d = '0;
          zero_d   = 1'b0;
          taken_d  = 1'b0;
          if (dec_legal) begin
            alu_a_d  = in_rs_i;
            alu_b_d  = dec_use_imm ? imm_sext : in_rt_i;
            alu_op_d = dec_op;
            wb_d     = dec_wb;
            mem_d    = dec_mem;
            br_d     = dec_br;
            err_d    = 1'b0;
            state_d  = S_ISSUE;
          end else begin
            // Illegal: ALU controls untouched, result reported directly.
            wb_d    = 1'b0;
            mem_d   = 1'b0;
            br_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        result_d = alu_z_i;
        zero_d   = alu_zero_i;
        taken_d  = br_q & alu_zero_i;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      wb_q     <= 1'b0;
      mem_q    <= 1'b0;
      br_q     <= 1'b0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      wb_q     <= wb_d;
      mem_q    <= mem_d;
      br_q     <= br_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign out_valid_o  = (state_q == S_DONE);
  assign out_result_o = result_q;
  assign out_zero_o   = zero_q;
  assign out_wb_o     = wb_q;
  assign out_mem_o    = mem_q;
  assign out_taken_o  = taken_q;
  assign out_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_y_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_alu_seq
// Purpose  : Self-checking bench for y_alu_seq with an attached behavioural
//            ALU, a vector table, random instructions against a reference
//            model, and hand-written back-pressure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_z;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_wb;
  logic        out_mem;
  logic        out_taken;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  // Bench-side tracking of what the ALU controls should currently hold.
  logic [2:0]  last_op = 3'b000;
  logic [31:0] last_a  = 32'd0;
  logic [31:0] last_b  = 32'd0;

  y_alu_seq #(.W(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_inst_i    (in_inst),
    .in_rs_i      (in_rs),
    .in_rt_i      (in_rt),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_z_i      (alu_z),
    .alu_zero_i   (alu_zero),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_zero_o   (out_zero),
    .out_wb_o     (out_wb),
    .out_mem_o    (out_mem),
    .out_taken_o  (out_taken),
    .out_err_o    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The combinational ALU the sequencer drives.
  always_comb begin
    alu_z = 32'd0;
    case (alu_op)
      3'b000: alu_z = alu_a & alu_b;
      3'b001: alu_z = alu_a | alu_b;
      3'b010: alu_z = alu_a + alu_b;
      3'b110: alu_z = alu_a - alu_b;
      3'b111: alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = 32'd0;
    endcase
  end
  assign alu_zero = (alu_z == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
    return {opc, 5'd1, 5'd2, imm};
  endfunction

  // Reference model: instruction semantics straight from the ISA rules.
  task automatic model(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                       output logic e_err, output logic [2:0] e_op, output logic [31:0] e_b,
                       output logic [31:0] e_res, output logic e_zero, output logic e_wb,
                       output logic e_mem, output logic e_taken);
    int simm;
    logic [5:0] opc;
    logic [5:0] fn;
    logic is_beq;
    opc = inst[31:26];
    fn  = inst[5:0];
    simm = $signed(inst[15:0]);
    e_err = 1'b0; e_op = 3'b000; e_b = 32'd0; e_res = 32'd0;
    e_wb = 1'b0; e_mem = 1'b0; is_beq = 1'b0;
    if (opc == 6'h00 && fn == 6'h20) begin e_op = 3'b010; e_b = rt; e_res = rs + rt; e_wb = 1'b1; end
    else if (opc == 6'h00 && fn == 6'h22) begin e_op = 3'b110; e_b = rt; e_res = rs - rt; e_wb = 1'b1; end
    else if (opc == 6'h00 && fn == 6'h24) begin e_op = 3'b000; e_b = rt; e_res = rs & rt; e_wb = 1'b1; end
    else if (opc == 6'h00 && fn == 6'h25) begin e_op = 3'b001; e_b = rt; e_res = rs | rt; e_wb = 1'b1; end
    else if (opc == 6'h00 && fn == 6'h2A) begin
      e_op = 3'b111; e_b = rt; e_res = (int'(rs) < int'(rt)) ? 32'd1 : 32'd0; e_wb = 1'b1;
    end
    else if (opc == 6'h08) begin e_op = 3'b010; e_b = simm; e_res = rs + simm; e_wb = 1'b1; end
    else if (opc == 6'h23 || opc == 6'h2B) begin e_op = 3'b010; e_b = simm; e_res = rs + simm; e_mem = 1'b1; end
    else if (opc == 6'h04) begin e_op = 3'b110; e_b = rt; e_res = rs - rt; is_beq = 1'b1; end
    else e_err = 1'b1;
    e_zero  = !e_err && (e_res == 32'd0);
    e_taken = is_beq && (rs == rt);
  endtask

  // One instruction with out_ready held high; checks latency and outputs.
  task automatic run_txn(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                         input logic e_err, input logic [2:0] e_op, input logic [31:0] e_b,
                         input logic [31:0] e_res, input logic e_zero, input logic e_wb,
                         input logic e_mem, input logic e_taken);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_rs     = rs;
    in_rt     = rt;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (!e_err) begin
      chk("alu_op", alu_op, e_op);
      chk("alu_a", alu_a, rs);
      chk("alu_b", alu_b, e_b);
      chk("early_valid", out_valid, 0);
      last_op = e_op;
      last_a  = rs;
      last_b  = e_b;
      @(negedge clk);
    end else begin
      chk("alu_op_kept", alu_op, last_op);
      chk("alu_a_kept", alu_a, last_a);
      chk("alu_b_kept", alu_b, last_b);
    end
    chk("out_valid", out_valid, 1);
    chk("out_result", out_result, e_res);
    chk("out_zero", out_zero, e_zero);
    chk("out_wb", out_wb, e_wb);
    chk("out_mem", out_mem, e_mem);
    chk("out_taken", out_taken, e_taken);
    chk("out_err", out_err, e_err);
    @(negedge clk);
    chk("retired_valid", out_valid, 0);
    chk("retired_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        err;
    logic [2:0]  op;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        wb;
    logic        mem;
    logic        taken;
  } vec_t;

  vec_t tv[14];

  initial begin
    logic        r_err, r_zero, r_wb, r_mem, r_taken;
    logic [2:0]  r_op;
    logic [31:0] r_b, r_res, inst, rs, rt;

    //            inst                  rs            rt            err op      b             res           z  wb mem tk
    tv[0]  = '{rtype(6'h20),        32'd5,        32'd7,        0, 3'b010, 32'd7,        32'd12,       0, 1, 0, 0};
    tv[1]  = '{itype(6'h04,16'h0),  32'd9,        32'd9,        0, 3'b110, 32'd9,        32'd0,        1, 0, 0, 1};
    tv[2]  = '{itype(6'h04,16'h0),  32'd9,        32'd8,        0, 3'b110, 32'd8,        32'd1,        0, 0, 0, 0};
    tv[3]  = '{rtype(6'h2A),        32'hFFFFFFFF, 32'd1,        0, 3'b111, 32'd1,        32'd1,        0, 1, 0, 0};
    tv[4]  = '{itype(6'h08,16'hFFFF), 32'd3,      32'd0,        0, 3'b010, 32'hFFFFFFFF, 32'd2,        0, 1, 0, 0};
    tv[5]  = '{rtype(6'h22),        32'd10,       32'd3,        0, 3'b110, 32'd3,        32'd7,        0, 1, 0, 0};
    tv[6]  = '{rtype(6'h24),        32'h0000F0F0, 32'h0000FF00, 0, 3'b000, 32'h0000FF00, 32'h0000F000, 0, 1, 0, 0};
    tv[7]  = '{rtype(6'h25),        32'h0000F0F0, 32'h00000F0F, 0, 3'b001, 32'h00000F0F, 32'h0000FFFF, 0, 1, 0, 0};
    tv[8]  = '{rtype(6'h22),        32'd5,        32'd5,        0, 3'b110, 32'd5,        32'd0,        1, 1, 0, 0};
    tv[9]  = '{itype(6'h23,16'h0004), 32'h100,    32'd0,        0, 3'b010, 32'd4,        32'h104,      0, 0, 1, 0};
    tv[10] = '{itype(6'h2B,16'hFFF0), 32'h20,     32'd0,        0, 3'b010, 32'hFFFFFFF0, 32'h10,       0, 0, 1, 0};
    tv[11] = '{itype(6'h3F,16'h1234), 32'd1,      32'd2,        1, 3'b000, 32'd0,        32'd0,        0, 0, 0, 0};
    tv[12] = '{rtype(6'h00),        32'd1,        32'd2,        1, 3'b000, 32'd0,        32'd0,        0, 0, 0, 0};
    tv[13] = '{rtype(6'h20),        32'hFFFFFFFF, 32'd1,        0, 3'b010, 32'd1,        32'd0,        1, 1, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_rs = '0; in_rt = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_out_flags", {out_result[0], out_zero, out_wb, out_mem, out_taken, out_err}, 0);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_txn(tv[i].inst, tv[i].rs, tv[i].rt, tv[i].err, tv[i].op, tv[i].b,
              tv[i].res, tv[i].zero, tv[i].wb, tv[i].mem, tv[i].taken);
    end

    // Randomized instructions against the reference model
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [5:0] fns[5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      kind = $urandom_range(0, 11);
      inst = $urandom;
      rs   = $urandom;
      rt   = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      case (kind)
        0, 1, 2, 3, 4: begin inst[31:26] = 6'h00; inst[5:0] = fns[kind]; end
        5:  inst[31:26] = 6'h08;
        6:  inst[31:26] = 6'h23;
        7:  inst[31:26] = 6'h2B;
        8:  inst[31:26] = 6'h04;
        9:  ;
        10: inst[31:26] = 6'h00;
        default: begin inst[31:26] = 6'h04; rt = rs; end
      endcase
      model(inst, rs, rt, r_err, r_op, r_b, r_res, r_zero, r_wb, r_mem, r_taken);
      run_txn(inst, rs, rt, r_err, r_op, r_b, r_res, r_zero, r_wb, r_mem, r_taken);
    end

    // Back-pressure with the next bundle waiting
    @(negedge clk);
    in_valid = 1'b1; in_inst = rtype(6'h20); in_rs = 32'd1; in_rt = 32'd2; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid", out_valid, 1);
    chk("bp_result", out_result, 3);
    in_valid = 1'b1; in_inst = rtype(6'h22); in_rs = 32'd9; in_rt = 32'd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", out_result, 3);
      chk("bp_hold_wb", out_wb, 1);
      chk("bp_hold_op", alu_op, 3'b010);
      chk("bp_hold_b", alu_b, 2);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_retire_valid", out_valid, 0);
    chk("bp_retire_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_op", alu_op, 3'b110);
    chk("bp_second_a", alu_a, 9);
    chk("bp_second_b", alu_b, 4);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_result", out_result, 5);
    @(negedge clk);
    chk("bp_second_retired", out_valid, 0);
    last_op = 3'b110; last_a = 32'd9; last_b = 32'd4;

    // Reset asserted while the instruction is in ISSUE
    @(negedge clk);
    in_valid = 1'b1; in_inst = rtype(6'h20); in_rs = 32'd5; in_rt = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    chk("mid_rst_ready_low", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    last_op = 3'b000; last_a = 32'd0; last_b = 32'd0;
    run_txn(rtype(6'h20), 32'd5, 32'd7, 0, 3'b010, 32'd7, 32'd12, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y_alu_seq.md
# y_alu_seq

Execute-stage sequencer that acts as the initiator for the combinational 32-bit ALU (and/or/add/sub/slt). It accepts one decoded-instruction bundle through a valid/ready handshake and decodes opcode/funct into the 3-bit ALU op. It drives the ALU operand/op ports from registers, captures the ALU result and zero flag, and presents a result bundle on an output valid/ready handshake. It sits between the operand-fetch stage and write-back/branch logic of the multi-cycle datapath.

## Interface
- W, 32, datapath width; immediates sign-extend from 16 bits to W
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; one clock, synchronous active-low reset
- in_valid  input  1  instruction bundle valid
- in_ready  output  1  block can accept a bundle
- in_inst  input  32  instruction word; opcode = [31:26], funct = [5:0], imm = [15:0]
- in_rs  input  W  rs register value
- in_rt  input  W  rt register value
- alu_a  output  W  ALU operand a (registered)
- alu_b  output  W  ALU operand b (registered)
- alu_op  output  3  ALU op (registered): 000 and, 001 or, 010 add, 110 sub, 111 slt
- alu_z  input  W  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero  input  1  ALU zero flag
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts the result
- out_result  output  W  captured ALU result; 0 on illegal
- out_zero  output  1  captured zero flag
- out_wb  output  1  result is destined for the register file (R-type, addi)
- out_mem  output  1  result is a memory address (lw, sw)
- out_taken  output  1  beq and zero
- out_err  output  1  illegal opcode/funct

## Operation
- Decode:
  - opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A → op 010/110/000/001/111; b = in_rt; wb = 1.
  - opcode 0x08 (addi) → 010; b = sext(imm); wb = 1.
  - 0x23 lw / 0x2B sw → 010; b = sext(imm); mem = 1.
  - 0x04 beq → 110; b = in_rt; branch.
  - Every other opcode or R-type funct is illegal.
- a = in_rs for every legal instruction.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, register a, b, op and the decode flags. Go to ISSUE, or go to DONE with err = 1 if the instruction is illegal. An illegal instruction leaves alu_a, alu_b and alu_op unchanged.
  - ISSUE: alu_a, alu_b and alu_op stay stable for the whole cycle. At the end of the cycle, capture alu_z → out_result and alu_zero → out_zero, and set out_taken = branch & alu_zero. Go to DONE.
  - DONE: out_valid = 1. All out_* signals are held stable until out_valid & out_ready, then go to IDLE.
- in_ready = rst_n & (state == IDLE). A new bundle is never accepted in the same cycle that a result is retired.
- out_wb, out_mem, out_taken and out_err are mutually exclusive; at most one is 1.

## Timing
- Reset (rst_n low at a clock edge): state IDLE; alu_a = 0, alu_b = 0, alu_op = 000. All out_* signals are 0 and out_valid = 0. in_ready = 0 while rst_n is low.
- Reset mid-operation (ISSUE or DONE) discards the in-flight bundle with no output.
- Legal instruction accepted at edge N: alu_* valid after edge N; out_valid = 1 after edge N+1.
- Illegal instruction accepted at edge N: out_valid = 1 after edge N.
- Retire at edge M (out_valid & out_ready): in_ready = 1 after edge M.
- Peak throughput is one legal instruction per 3 cycles.
- Back-pressure: while out_ready = 0, out_* signals and alu_* signals are frozen and in_ready = 0.
- Arithmetic is W-bit modulo 2^W; overflow is not flagged. Sign extension replicates imm[15].

## Test plan
- Reset, then R-type add (funct 0x20), rs = 5, rt = 7, out_ready = 1 → alu_op = 010 one cycle after accept; out_valid two cycles after accept with out_result = 12, out_zero = 0, out_wb = 1; in_ready returns the cycle after retire.
- beq, rs = rt = 9 → alu_op = 110, out_result = 0, out_zero = 1, out_taken = 1. Repeat with rt = 8 → out_taken = 0, out_result = 1.
- slt, rs = 0xFFFFFFFF, rt = 1 → out_result = 1, alu_op = 111. addi, rs = 3, imm = 0xFFFF → alu_b = 0xFFFFFFFF, out_result = 2.
- Back-pressure: hold out_ready = 0 for 5 cycles after out_valid with in_valid held high and the next bundle presented → out_* stable, in_ready = 0 throughout. The second bundle is accepted only after retire.
- Illegal opcode 0x3F → out_valid the cycle after accept, out_err = 1, out_result = 0, alu_op unchanged from the previous instruction. R-type funct 0x00 is also flagged illegal.
- Deassert rst_n during ISSUE → after that edge out_valid = 0, alu_* = 0, in_ready = 0. After rst_n rises, a new add completes normally.
